// File: rtl/key_pkg.sv
// Shared key codes, fire FSM state type and key classification helper for
// the keyboard command front end.
package key_pkg;

    // USB HID usage codes recognised by the front end
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;

    // Fire path states: waiting, confirming a press, auto-repeating
    typedef enum logic [1:0] {
        F_IDLE     = 2'd0,
        F_DEBOUNCE = 2'd1,
        F_HELD     = 2'd2
    } fire_state_t;

    // True for the four native movement keys (W/A/S/D)
    function automatic bit is_move_key(input logic [7:0] code);
        return (code == KEY_W) || (code == KEY_A) ||
               (code == KEY_S) || (code == KEY_D);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Generic frame-tick debouncer: a candidate value must be seen on FRAMES
// consecutive ticks before it is published. Any value (including zero) goes
// through the same path, so key release is debounced too.
module key_debounce #(
    parameter int WIDTH  = 16,
    parameter int FRAMES = 2
) (
    input  logic             clk,
    input  logic             reset,      // synchronous, active-low
    input  logic             tick,
    input  logic [WIDTH-1:0] candidate,
    output logic [WIDTH-1:0] value,
    output logic             valid
);

    localparam logic [3:0] LIMIT = 4'(FRAMES);

    logic [WIDTH-1:0] prev_reg;
    logic [3:0]       cnt_reg;
    logic [3:0]       cnt_next;
    logic [WIDTH-1:0] value_reg;
    logic             valid_reg;

    // Stability count for this tick: extend the run (saturating) or restart at 1
    always_comb begin
        cnt_next = 4'd1;
        if (candidate == prev_reg) begin
            cnt_next = (cnt_reg >= LIMIT) ? LIMIT : cnt_reg + 4'd1;
        end
    end

    // Track the previous candidate and publish once it has been stable long enough
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_reg  <= '0;
            cnt_reg   <= '0;
            value_reg <= '0;
            valid_reg <= 1'b0;
        end else if (tick) begin
            prev_reg <= candidate;
            cnt_reg  <= cnt_next;
            if (cnt_next == LIMIT) begin
                value_reg <= candidate;
                valid_reg <= |candidate;
            end
        end
    end

    assign value = value_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/key_ctrl.sv
// Keyboard command front end for the tank. Turns the raw two-slot keycode
// word into a debounced, frame-aligned movement code and a single-cycle fire
// pulse with auto-repeat. All decisions happen on frame ticks only.
// Optional build macro KEY_ARROW_EN: arrow keys also count as movement keys
// and are translated to their W/A/S/D equivalents before debouncing.
module key_ctrl
    import key_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 2,
    parameter int REPEAT_FRAMES   = 20
) (
    input  logic        Clk,
    input  logic        Reset,          // synchronous, active-low
    input  logic        frame_clk,
    input  logic [15:0] keycode,
    output logic [15:0] move_keycode,
    output logic        move_valid,
    output logic        fire,
    output logic        frame_tick
);

    localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_FRAMES);
    localparam logic [7:0] REP_LAST = 8'(REPEAT_FRAMES - 1);

    // Map one slot byte to a zero-extended movement code, or zero if not a movement key
    function automatic logic [15:0] translate(input logic [7:0] code);
        logic [15:0] result;
        result = 16'h0000;
        if (is_move_key(code)) begin
            result = {8'h00, code};
        end
`ifdef KEY_ARROW_EN
        else begin
            case (code)
                KEY_UP:    result = {8'h00, KEY_W};
                KEY_LEFT:  result = {8'h00, KEY_A};
                KEY_DOWN:  result = {8'h00, KEY_S};
                KEY_RIGHT: result = {8'h00, KEY_D};
                default:   result = 16'h0000;
            endcase
        end
`endif
        return result;
    endfunction

    logic        frame_clk_q_reg;
    logic        frame_tick_reg;
    logic [15:0] slot_code [2];
    logic [1:0]  slot_space;
    logic [15:0] candidate;
    logic        space_seen;

    fire_state_t fire_state_reg;
    logic [3:0]  deb_cnt_reg;
    logic [7:0]  rep_cnt_reg;
    logic        fire_reg;

    // Rising-edge detect of the frame strobe, registered so reset forces it low
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            frame_clk_q_reg <= 1'b0;
            frame_tick_reg  <= 1'b0;
        end else begin
            frame_clk_q_reg <= frame_clk;
            frame_tick_reg  <= frame_clk & ~frame_clk_q_reg;
        end
    end

    // Per-slot decode: movement translation and space detection
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        assign slot_code[gi]  = translate(keycode[gi*8 +: 8]);
        assign slot_space[gi] = (keycode[gi*8 +: 8] == KEY_SPACE);
    end

    // Slot0 has priority; unknown keys in slot0 decode to zero and fall through to slot1
    always_comb begin
        candidate = slot_code[1];
        if (slot_code[0] != 16'h0000) begin
            candidate = slot_code[0];
        end
    end

    assign space_seen = |slot_space;

    // The keycode word present on a tick cycle is that frame's sample
    key_debounce #(
        .WIDTH  (16),
        .FRAMES (DEBOUNCE_FRAMES)
    ) u_move_debounce (
        .clk       (Clk),
        .reset     (Reset),
        .tick      (frame_tick_reg),
        .candidate (candidate),
        .value     (move_keycode),
        .valid     (move_valid)
    );

    // Fire FSM: debounce the space key, then auto-repeat every REPEAT_FRAMES while held
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            fire_state_reg <= F_IDLE;
            deb_cnt_reg    <= '0;
            rep_cnt_reg    <= '0;
            fire_reg       <= 1'b0;
        end else begin
            fire_reg <= 1'b0;
            if (frame_tick_reg) begin
                case (fire_state_reg)
                    F_IDLE: begin
                        if (space_seen) begin
                            if (DEB_LAST == 4'd1) begin
                                // Single-frame debounce: the first sighting is already accepted
                                fire_state_reg <= F_HELD;
                                fire_reg       <= 1'b1;
                                rep_cnt_reg    <= '0;
                                deb_cnt_reg    <= 4'd1;
                            end else begin
                                fire_state_reg <= F_DEBOUNCE;
                                deb_cnt_reg    <= 4'd1;
                            end
                        end
                    end
                    F_DEBOUNCE: begin
                        if (!space_seen) begin
                            fire_state_reg <= F_IDLE;
                            deb_cnt_reg    <= '0;
                        end else if (deb_cnt_reg + 4'd1 >= DEB_LAST) begin
                            fire_state_reg <= F_HELD;
                            fire_reg       <= 1'b1;
                            rep_cnt_reg    <= '0;
                            deb_cnt_reg    <= DEB_LAST;
                        end else begin
                            deb_cnt_reg <= deb_cnt_reg + 4'd1;
                        end
                    end
                    F_HELD: begin
                        if (!space_seen) begin
                            fire_state_reg <= F_IDLE;
                            deb_cnt_reg    <= '0;
                            rep_cnt_reg    <= '0;
                        end else if (rep_cnt_reg == REP_LAST) begin
                            fire_reg    <= 1'b1;
                            rep_cnt_reg <= '0;
                        end else begin
                            rep_cnt_reg <= rep_cnt_reg + 8'd1;
                        end
                    end
                    default: begin
                        fire_state_reg <= F_IDLE;
                        deb_cnt_reg    <= '0;
                        rep_cnt_reg    <= '0;
                    end
                endcase
            end
        end
    end

    assign fire       = fire_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_key_ctrl.sv
// Directed bench for key_ctrl with DEBOUNCE_FRAMES=2, REPEAT_FRAMES=20.
// Honours KEY_ARROW_EN for the arrow-key expectation.
module tb_key_ctrl;

    logic        clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic [15:0] keycode;
    logic [15:0] move_keycode;
    logic        move_valid;
    logic        fire;
    logic        frame_tick;

    int n_checks = 0;
    int n_errors = 0;

`ifdef KEY_ARROW_EN
    localparam logic [15:0] ARROW_EXP = 16'h001A;
`else
    localparam logic [15:0] ARROW_EXP = 16'h0000;
`endif

    key_ctrl #(
        .DEBOUNCE_FRAMES (2),
        .REPEAT_FRAMES   (20)
    ) dut (
        .Clk          (clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .keycode      (keycode),
        .move_keycode (move_keycode),
        .move_valid   (move_valid),
        .fire         (fire),
        .frame_tick   (frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One frame: strobe high 4 cycles, low 4 cycles; count fire and tick cycles
    task automatic frame_step(output int fires, output int ticks);
        fires = 0;
        ticks = 0;
        @(negedge clk) frame_clk = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (fire === 1'b1) fires++;
            if (frame_tick === 1'b1) ticks++;
            if (i == 3) frame_clk = 1'b0;
        end
    endtask

    task automatic frame_chk(input string tag, input logic [15:0] kc,
                             input logic [15:0] exp_move, input int exp_fire);
        int f;
        int t;
        keycode = kc;
        frame_step(f, t);
        check({tag, "_move"}, move_keycode, exp_move);
        check({tag, "_valid"}, move_valid, exp_move != 16'h0000);
        check({tag, "_fire"}, f, exp_fire);
        check({tag, "_tick"}, t, 1);
        $display("frame %s kc=%h move=%h valid=%b fires=%0d", tag, kc, move_keycode, move_valid, f);
    endtask

    initial begin
        int f;
        int t;
        Reset     = 1'b0;
        frame_clk = 1'b0;
        keycode   = 16'h001A;

        // Reset held with W present and a frame strobe: outputs must stay zero
        @(negedge clk) frame_clk = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_out", {move_keycode, move_valid, fire, frame_tick}, 32'h0);
        end
        frame_clk = 1'b0;
        @(negedge clk);
        check("reset_out_low", {move_keycode, move_valid, fire, frame_tick}, 32'h0);
        Reset = 1'b1;

        // W held two frames
        frame_chk("w1", 16'h001A, 16'h0000, 0);
        frame_chk("w2", 16'h001A, 16'h001A, 0);

        // A in slot0 beats D in slot1, then D alone
        frame_chk("ad1", 16'h0704, 16'h001A, 0);
        frame_chk("ad2", 16'h0704, 16'h0004, 0);
        frame_chk("ad3", 16'h0704, 16'h0004, 0);
        frame_chk("d1",  16'h0007, 16'h0004, 0);
        frame_chk("d2",  16'h0007, 16'h0007, 0);

        // Release is debounced too
        frame_chk("rel1", 16'h0000, 16'h0007, 0);
        frame_chk("rel2", 16'h0000, 16'h0000, 0);

        // Single-frame glitch is rejected
        frame_chk("gl1", 16'h001A, 16'h0000, 0);
        frame_chk("gl2", 16'h0000, 16'h0000, 0);
        frame_chk("gl3", 16'h0000, 16'h0000, 0);

        // Space held 45 frames: pulses on frames 2, 22, 42
        for (int i = 1; i <= 45; i++) begin
            frame_chk($sformatf("sp%0d", i), 16'h002C, 16'h0000,
                      (i == 2 || i == 22 || i == 42) ? 1 : 0);
        end
        for (int i = 1; i <= 25; i++) begin
            frame_chk($sformatf("sprel%0d", i), 16'h0000, 16'h0000, 0);
        end

        // Space plus W: movement and fire together
        frame_chk("spw1", 16'h2C1A, 16'h0000, 0);
        frame_chk("spw2", 16'h2C1A, 16'h001A, 1);
        for (int i = 3; i <= 21; i++) begin
            frame_chk($sformatf("spw%0d", i), 16'h2C1A, 16'h001A, 0);
        end

        // Reset in F_HELD just before the next repeat: no pulse, outputs cleared
        Reset = 1'b0;
        frame_step(f, t);
        check("rst_held_fire", f, 0);
        check("rst_held_tick", t, 0);
        check("rst_held_move", move_keycode, 16'h0000);
        check("rst_held_valid", move_valid, 1'b0);
        $display("frame rst_held move=%h fires=%0d", move_keycode, f);
        Reset = 1'b1;

        // Fire FSM restarts from idle after reset
        frame_chk("post1", 16'h2C1A, 16'h0000, 0);
        frame_chk("post2", 16'h2C1A, 16'h001A, 1);
        frame_chk("post3", 16'h0000, 16'h001A, 0);
        frame_chk("post4", 16'h0000, 16'h0000, 0);

        // Arrow up: translated only when the arrow feature is built in
        frame_chk("arr1", 16'h0052, 16'h0000, 0);
        frame_chk("arr2", 16'h0052, ARROW_EXP, 0);
        frame_chk("arr3", 16'h0000, ARROW_EXP, 0);
        frame_chk("arr4", 16'h0000, 16'h0000, 0);

        // Unknown key in slot0 does not block W in slot1
        frame_chk("unk1", 16'h1A33, 16'h0000, 0);
        frame_chk("unk2", 16'h1A33, 16'h001A, 0);

        // Both slots movement: slot0 (A) wins over slot1 (W)
        frame_chk("pri1", 16'h1A04, 16'h001A, 0);
        frame_chk("pri2", 16'h1A04, 16'h0004, 0);
        frame_chk("pri3", 16'h0000, 16'h0004, 0);
        frame_chk("pri4", 16'h0000, 16'h0000, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/key_ctrl.md
Name: key_ctrl

Overview:
- Keyboard command front end, directly upstream of the tank movement block.
- Takes the raw 16-bit keycode word from the USB keyboard path in the Clk domain. Produces a debounced, frame-aligned movement keycode for the tank and a single-cycle fire pulse for the projectile logic.
- All outputs change only on frame boundaries, so the tank sees one stable command per frame.

Parameters:
- DEBOUNCE_FRAMES, 2, consecutive frames a movement/fire key must be seen before acceptance (1..15)
- REPEAT_FRAMES, 20, frames between auto-repeat fire pulses while fire is held (1..255)

Ports:
- Clk  input  1  system clock (50 MHz)
- Reset  input  1  synchronous, active-low reset
- frame_clk  input  1  VGA frame strobe, synchronous to Clk, level signal; its rising edge marks a frame
- keycode  input  16  two key slots: slot0 = [7:0], slot1 = [15:8]; 8'h00 = empty
- move_keycode  output  16  accepted movement key, zero-extended (16'h001A W, 16'h0004 A, 16'h0016 S, 16'h0007 D, 16'h0000 none)
- move_valid  output  1  high while move_keycode is non-zero
- fire  output  1  one-Clk-cycle pulse on accepted fire (space, 8'h2C)
- frame_tick  output  1  one-cycle pulse on frame_clk rising edge (for downstream reuse)

Behaviour:
- Reset (Reset==0 at posedge Clk): move_keycode=0, move_valid=0, fire=0, frame_tick=0, all counters 0, fire FSM=F_IDLE, frame_clk edge register=0. Reset takes priority over every other event, including mid-debounce and mid-repeat.
- frame_tick: frame_clk registered once; tick = frame_clk & ~frame_clk_q. Tick is high exactly one cycle, one cycle after the edge.
- keycode sampled into a register only on tick cycles; all decisions below use that sample.
- Movement candidate:
  - Slot0 if it holds W/A/S/D; else slot1 if it holds W/A/S/D; else none.
  - Slot0 wins when both slots hold movement keys.
- Movement debounce (per tick):
  - If candidate equals the previous candidate, increment stability counter, saturating at DEBOUNCE_FRAMES. Otherwise load counter with 1.
  - When counter reaches DEBOUNCE_FRAMES, move_keycode <= candidate, one cycle after the tick.
  - Release (candidate none) follows the same debounce path to 16'h0000.
  - move_valid is registered together with move_keycode.
- Fire FSM, advancing on tick cycles only:
  - F_IDLE: space present in either slot -> F_DEBOUNCE, cnt=1.
  - F_DEBOUNCE: space absent -> F_IDLE. cnt==DEBOUNCE_FRAMES -> F_HELD, fire=1 for one cycle, rep=0. Otherwise cnt++.
  - F_HELD: space absent -> F_IDLE, no pulse. Otherwise rep++; when rep==REPEAT_FRAMES-1, fire=1 and rep=0.
  - With DEBOUNCE_FRAMES=1, fire is issued on the first tick that sees space.
- Movement and fire are independent: space plus W in the two slots yields W movement and fire.
- Unknown keys are ignored. They do not block a valid key in the other slot.
- Counters never wrap: debounce saturates; rep resets on match.
- Latency: key stable from tick N -> output changes one Clk cycle after tick N+DEBOUNCE_FRAMES-1.

Optional Feature:
- KEY_ARROW_EN defined: arrow keys are also movement candidates and are translated before debounce: 8'h52 -> 16'h001A, 8'h50 -> 16'h0004, 8'h51 -> 16'h0016, 8'h4F -> 16'h0007. Slot priority is unchanged.
- KEY_ARROW_EN undefined: arrow codes are treated as unknown keys.

Decomposition:
- Package key_pkg:
  - localparams KEY_W, KEY_A, KEY_S, KEY_D, KEY_SPACE, KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT (8-bit)
  - enum fire_state_t {F_IDLE, F_DEBOUNCE, F_HELD}
  - function is_move_key(8-bit) returning bit
- One sub-module, key_debounce: generic frame-tick debouncer with stability counter, instantiated for the movement path. The fire FSM stays in the top level.

Test Plan:
- Reset low 3 cycles with keycode=16'h001A -> all outputs 0 throughout; after release, W held 2 frames -> move_keycode=16'h001A one cycle after 2nd tick, move_valid=1.
- keycode=16'h0704 (A slot0, D slot1) for 3 frames -> move_keycode=16'h0004; switch to 16'h0007 -> output stays 16'h0004 until 2nd tick of the new value, then 16'h0007.
- W present for 1 frame only (glitch), DEBOUNCE_FRAMES=2 -> move_keycode stays 16'h0000.
- keycode=16'h002C held 45 frames, REPEAT_FRAMES=20 -> fire pulses at tick 2, 22, 42 (3 pulses, each exactly 1 cycle); release -> no further pulses.
- keycode=16'h2C1A held -> move_keycode=16'h001A and fire pulse on the same tick; Reset asserted in F_HELD -> fire FSM to F_IDLE, no pulse that cycle.
- KEY_ARROW_EN defined, keycode=16'h0052 for 2 frames -> move_keycode=16'h001A; undefined -> stays 16'h0000.
